// File: rtl/alu_seq_exec_if.sv
// rtl/alu_seq_exec_if.sv - issue/result bundle between the execute-stage control and the ALU
interface alu_seq_exec_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             sign;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_op, op_a, op_b,
    input  result, zero, sign, busy, done
  );

  modport slave (
    input  start, alu_op, op_a, op_b,
    output result, zero, sign, busy, done
  );
endinterface

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - execute-stage ALU: single-cycle ops, bit-serial shifts, iterative shift-add MUL
module alu_seq_exec #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  alu_seq_exec_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT = 4'd6,  OP_SGT = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_MUL = 4'd11;
  localparam logic [3:0] OP_INC = 4'd12, OP_DEC = 4'd13;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] shv;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  logic [4:0]       amt;
  logic             is_shift;
  logic             is_mul;
  logic [WIDTH-1:0] alu_r;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] run_r;

  assign amt      = bus.op_b[4:0];
  assign is_shift = (bus.alu_op == OP_SLL) || (bus.alu_op == OP_SRL) || (bus.alu_op == OP_SRA);
  assign is_mul   = (bus.alu_op == OP_MUL);

  // Shifts only reach this path with a zero amount, so they pass op_a through.
  always_comb begin
    alu_r = '0;
    case (bus.alu_op)
      OP_ADD: alu_r = bus.op_a + bus.op_b;
      OP_SUB: alu_r = bus.op_a - bus.op_b;
      OP_AND: alu_r = bus.op_a & bus.op_b;
      OP_OR:  alu_r = bus.op_a | bus.op_b;
      OP_XOR: alu_r = bus.op_a ^ bus.op_b;
      OP_NOR: alu_r = ~(bus.op_a | bus.op_b);
      OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      OP_SGT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) > $signed(bus.op_b))};
      OP_SLL, OP_SRL, OP_SRA: alu_r = bus.op_a;
      OP_INC: alu_r = bus.op_a + 1'b1;
      OP_DEC: alu_r = bus.op_a - 1'b1;
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    sh_next = {shv[WIDTH-1], shv[WIDTH-1:1]};
    if (op_q == OP_SLL)
      sh_next = shv << 1;
    else if (op_q == OP_SRL)
      sh_next = shv >> 1;
    acc_next = mplier[0] ? acc + mcand : acc;
    run_r    = (op_q == OP_MUL) ? acc_next : sh_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      shv        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      bus.result <= '0;
      bus.zero   <= 1'b1;
      bus.sign   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.alu_op;
            if (is_shift && amt != 5'd0) begin
              shv      <= bus.op_a;
              cnt      <= CW'(amt);
              bus.busy <= 1'b1;
              state    <= RUN;
            end else if (is_mul && MUL_EN) begin
              mcand    <= bus.op_a;
              mplier   <= bus.op_b;
              acc      <= '0;
              cnt      <= CW'(WIDTH);
              bus.busy <= 1'b1;
              state    <= RUN;
            end else begin
              bus.result <= alu_r;
              bus.zero   <= (alu_r == '0);
              bus.sign   <= alu_r[WIDTH-1];
              bus.done   <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (op_q == OP_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            shv <= sh_next;
          end
          // The last step's value goes straight to result; flags never move mid-run.
          if (cnt == CW'(1)) begin
            bus.result <= run_r;
            bus.zero   <= (run_r == '0);
            bus.sign   <= run_r[WIDTH-1];
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - scoreboard bench for alu_seq_exec with a plain-arithmetic reference model
module tb_alu_seq_exec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_exec_if #(.WIDTH(32)) bus();
  alu_seq_exec #(.WIDTH(32), .MUL_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    int          edg;
  } exp_t;

  exp_t        sb[$];
  int          edge_n = 0;
  int          free_edge = 0;
  int          busy_lo = 0;
  int          busy_hi = -1;
  int          last_acc = -1;
  int          done_cnt = 0;
  logic [31:0] last_res = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [31:0] r;
    s = b % 32;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  r = a << s;
      4'd9:  r = a >> s;
      4'd10: r = $unsigned($signed(a) >>> s);
      4'd11: r = a * b;
      4'd12: r = a + 32'd1;
      4'd13: r = a - 32'd1;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if (op >= 4'd8 && op <= 4'd10 && (b % 32) != 0) return int'(b % 32) + 1;
    if (op == 4'd11) return 33;
    return 1;
  endfunction

  // Reference: an op is taken at any edge where start is high and the previous op has finished.
  always @(posedge clk) begin : model
    int   l;
    exp_t e;
    edge_n++;
    if (!rst && bus.start && edge_n >= free_edge) begin
      l = ref_lat(bus.alu_op, bus.op_b);
      e.res = ref_res(bus.alu_op, bus.op_a, bus.op_b);
      e.edg = edge_n + l - 1;
      sb.push_back(e);
      free_edge = edge_n + l;
      last_acc = edge_n;
      if (l > 1) begin
        busy_lo = edge_n;
        busy_hi = edge_n + l - 2;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      chk("busy_done_excl", {31'b0, bus.busy & bus.done}, 32'd0);
      chk("busy", {31'b0, bus.busy}, {31'b0, (edge_n >= busy_lo && edge_n <= busy_hi)});
      if (sb.size() > 0 && sb[0].edg < edge_n) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_missing: no done by edge %0d, expected at edge %0d", edge_n, sb[0].edg);
        void'(sb.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        if (sb.size() == 0 || sb[0].edg != edge_n) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: done at edge %0d, expected edge %0d", edge_n,
                   (sb.size() == 0) ? -1 : sb[0].edg);
        end else begin
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("zero", {31'b0, bus.zero}, {31'b0, (e.res == 32'd0)});
          chk("sign", {31'b0, bus.sign}, {31'b0, e.res[31]});
          last_res = e.res;
        end
      end else begin
        chk("result_hold", bus.result, last_res);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = op;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.start  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (last_acc == edge_n) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL accept_timeout: op %0d not accepted within 100 edges", op);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL idle_timeout: %0d ops still outstanding", sb.size());
  endtask

  initial begin
    int          d0;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bus.start  = 1'b0;
    bus.alu_op = 4'd0;
    bus.op_a   = 32'd0;
    bus.op_b   = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", {31'b0, bus.zero}, 32'd1);
    chk("rst_sign", {31'b0, bus.sign}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(4'd0, 32'h7FFF_FFFF, 32'd1);
    wait_idle();
    chk("add_ovf", bus.result, 32'h8000_0000);
    chk("add_ovf_sign", {31'b0, bus.sign}, 32'd1);
    chk("add_ovf_zero", {31'b0, bus.zero}, 32'd0);

    issue(4'd1, 32'd5, 32'd5);
    wait_idle();
    chk("sub_zero", {31'b0, bus.zero}, 32'd1);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1);
    wait_idle();
    chk("slt_neg", bus.result, 32'd1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    wait_idle();
    chk("sgt_neg", bus.result, 32'd0);

    issue(4'd10, 32'h8000_0000, 32'd4);
    wait_idle();
    chk("sra4", bus.result, 32'hF800_0000);
    issue(4'd8, 32'h1234, 32'd0);
    wait_idle();
    chk("sll0", bus.result, 32'h1234);

    issue(4'd11, 32'd7, 32'hFFFF_FFFD);
    wait_idle();
    chk("mul_neg", bus.result, 32'hFFFF_FFEB);

    // ADD held on start throughout a MUL run: only taken once the MUL completes.
    issue(4'd11, 32'd6, 32'd9);
    issue(4'd0, 32'h10, 32'h20);
    wait_idle();
    chk("held_add", bus.result, 32'h30);

    issue(4'd11, 32'd9, 32'd9);
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    free_edge = 0;
    busy_hi = -1;
    last_res = 32'd0;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_done", {31'b0, bus.done}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_zero", {31'b0, bus.zero}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(4'd0, 32'd2, 32'd3);
    wait_idle();
    chk("add_after_rst", bus.result, 32'd5);

    d0 = done_cnt;
    issue(4'd9, 32'h10, 32'd2);
    issue(4'd0, 32'd1, 32'd1);
    wait_idle();
    chk("b2b_add", bus.result, 32'd2);
    chk("b2b_done_pulses", done_cnt - d0, 32'd2);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      issue(op, a, b);
      if ($urandom_range(0, 3) == 0) begin
        bus.start = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU that consumes the final operand pair produced by the conditional-move operand selector (operand A, operand B) together with the decoded ALU opcode.
- Single-cycle ops (add/sub/logic/compare/inc/dec) complete in one clock. Shifts run one bit per cycle; MUL is an iterative 32-step shift-add.
- A start/busy/done handshake lets the control FSM stall the pipeline while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- MUL_EN, 1, 1 = iterative multiplier present; 0 = MUL opcode behaves as reserved.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only when accept condition holds
- alu_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SGT, 8 SLL, 9 SRL, 10 SRA, 11 MUL, 12 INC, 13 DEC, 14-15 reserved
- op_a  input  WIDTH  operand A (aluip_fin1 from selector)
- op_b  input  WIDTH  operand B (aluip_fin2); shift amount = op_b[4:0]
- result  output  WIDTH  registered result, held until next accepted start
- zero  output  1  registered, 1 when result == 0
- sign  output  1  registered, result[WIDTH-1]
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (async, any time incl. mid-op): state=IDLE, result=0, zero=1, sign=0, busy=0, done=0, internal counters/accumulators 0. An in-flight op is discarded; no done is produced for it.
- States: IDLE, RUN. Accept condition: state==IDLE (done may be high in the same cycle, so back-to-back issue is allowed). start while busy is ignored, and operand/opcode changes during RUN have no effect (operands latched at accept).
- Latency L = number of edges from the accepting edge to the edge that raises done, inclusive:
  - Single-cycle ops (0-7, 12, 13, reserved, shift with amount 0, MUL when MUL_EN=0): L=1. Result, flags and done are registered at the accepting edge; the FSM stays in IDLE.
  - Shifts with amount s>0: L=s+1. The accepting edge latches operands, loads counter=s and enters RUN with busy=1. Each RUN edge shifts by one bit and decrements the counter. The edge that shifts with counter==1 writes result, pulses done, clears busy and returns to IDLE.
  - MUL: L=33. The accepting edge loads multiplicand, multiplier and a zeroed accumulator. Each of the 32 RUN edges adds the multiplicand if the multiplier LSB is 1, then shifts. The 32nd edge writes the low WIDTH bits of the product. The result is identical for signed and unsigned operands (low word only).
- Arithmetic: ADD/SUB/INC/DEC are modulo 2^WIDTH with no overflow output. SLT/SGT are signed two's-complement compares returning 1 or 0. SRA replicates the sign bit. NOR = ~(a|b). Reserved opcodes give result 0.
- done: high for exactly one cycle per accepted op. busy and done are never high together. busy is 0 for single-cycle ops.
- Flags update only when result is written (at the done edge), never during RUN.
- result is not modified during RUN; the previous value is held until the done edge.

Test Plan:
- Reset, then ADD op_a=0x7FFFFFFF, op_b=1 with start for one cycle -> next cycle done=1, result=0x80000000, sign=1, zero=0, busy=0.
- SUB op_a=5, op_b=5 -> L=1, result=0, zero=1. Then SLT op_a=0xFFFFFFFF (−1), op_b=1 -> result=1. Then SGT with the same operands -> result=0.
- SRA op_a=0x80000000, op_b=4 -> busy=1 for 4 cycles, done at edge 5, result=0xF8000000. SLL with op_b=0 and op_a=0x1234 -> L=1, result=0x1234.
- MUL op_a=7, op_b=0xFFFFFFFD (−3) -> done exactly 33 edges after accept, result=0xFFFFFFEB. Holding start=1 with a different ADD during RUN -> ignored. With start still high in the done cycle, the ADD is accepted at the next edge.
- Assert rst at edge 10 of a MUL -> busy=0, done=0, result=0, zero=1 immediately (async). No done follows. A fresh ADD 2+3 after reset -> result=5.
- Back-to-back: ADD issued in the cycle done pulses for a prior SRL (op_a=0x10, op_b=2) -> SRL result=0x4, then ADD result valid on the following edge. Exactly two done pulses observed.
